// File: rtl/conv_pkg.sv
// Shared constants, types and helpers for the 5x5 convolution filter.
// The identity kernel is what the filter loads on reset.
package conv_pkg;
    localparam int PIX_W   = 8;
    localparam int KERN_N  = 5;
    localparam int KERN_SZ = KERN_N * KERN_N;
    localparam int COEF_W  = 8;
    localparam int PROD_W  = 17;
    localparam int ROW_W   = 20;
    localparam int SUM_W   = 22;
    localparam int LAT     = 7;
    localparam int CENTRE  = 12;

    localparam int STAT_VS = 2;
    localparam int STAT_HS = 1;
    localparam int STAT_DE = 0;

    typedef logic [KERN_SZ-1:0][COEF_W-1:0] kern_t;
    typedef logic [KERN_N-1:0][PIX_W-1:0]   col_t;

    function automatic kern_t ident_kern(input int shift);
        kern_t k;
        k = '0;
        k[CENTRE] = COEF_W'(1 << shift);
        return k;
    endfunction
endpackage

// File: rtl/conv5x5_chan.sv
// One colour channel: 5x5 window, 25 multipliers, two-level adder tree,
// normalising shift and 0..255 saturation, with centre-pixel bypass.
module conv5x5_chan
    import conv_pkg::*;
#(
    parameter int NORM_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  col_t             i_col,
    input  kern_t            i_kern,
    input  logic             i_byp,
    output logic [PIX_W-1:0] o_pix
);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'(255);

    // window index [col][row]; col 4 is the newest column
    logic [KERN_N-1:0][KERN_N-1:0][PIX_W-1:0] r_win;
    logic signed [PROD_W-1:0] w_prod [KERN_SZ];
    logic signed [PROD_W-1:0] r_prod [KERN_SZ];
    logic signed [ROW_W-1:0]  w_row  [KERN_N];
    logic signed [ROW_W-1:0]  r_row  [KERN_N];
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  r_sum;
    logic signed [SUM_W-1:0]  w_shr;
    logic [PIX_W-1:0]         w_sat;
    logic [PIX_W-1:0]         r_cen4, r_cen5, r_cen6;
    logic                     r_byp4, r_byp5, r_byp6;
    logic [PIX_W-1:0]         r_pix;

    // unsigned pixel times signed coefficient, both widened to 17 bits
    always_comb begin
        for (int r = 0; r < KERN_N; r++) begin
            for (int c = 0; c < KERN_N; c++) begin
                w_prod[r*KERN_N+c] =
                    PROD_W'($signed({1'b0, r_win[c][r]})) *
                    PROD_W'($signed(i_kern[r*KERN_N+c]));
            end
        end
    end

    // first adder level: one partial sum per kernel row
    always_comb begin
        for (int r = 0; r < KERN_N; r++) begin
            w_row[r] = '0;
            for (int c = 0; c < KERN_N; c++) begin
                w_row[r] = w_row[r] + ROW_W'(r_prod[r*KERN_N+c]);
            end
        end
    end

    // second adder level: total of the five row sums
    always_comb begin
        w_sum = '0;
        for (int r = 0; r < KERN_N; r++) begin
            w_sum = w_sum + SUM_W'(r_row[r]);
        end
    end

    // normalise and clamp the sum into the pixel range
    always_comb begin
        w_shr = r_sum >>> NORM_SHIFT;
        w_sat = w_shr[PIX_W-1:0];
        if (w_shr[SUM_W-1]) begin
            w_sat = '0;
        end else if (w_shr > PIX_MAX) begin
            w_sat = '1;
        end
    end

    // window shift, product/adder pipeline and bypass alignment
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_win  <= '0;
            for (int i = 0; i < KERN_SZ; i++) r_prod[i] <= '0;
            for (int i = 0; i < KERN_N; i++)  r_row[i]  <= '0;
            r_sum  <= '0;
            r_cen4 <= '0;
            r_cen5 <= '0;
            r_cen6 <= '0;
            r_byp4 <= 1'b0;
            r_byp5 <= 1'b0;
            r_byp6 <= 1'b0;
            r_pix  <= '0;
        end else begin
            r_win  <= {i_col, r_win[KERN_N-1:1]};
            for (int i = 0; i < KERN_SZ; i++) r_prod[i] <= w_prod[i];
            for (int i = 0; i < KERN_N; i++)  r_row[i]  <= w_row[i];
            r_sum  <= w_sum;
            r_cen4 <= r_win[2][2];
            r_cen5 <= r_cen4;
            r_cen6 <= r_cen5;
            r_byp4 <= i_byp;
            r_byp5 <= r_byp4;
            r_byp6 <= r_byp5;
            r_pix  <= r_byp6 ? r_cen6 : w_sat;
        end
    end

    assign o_pix = r_pix;
endmodule

// File: rtl/conv5x5_filter.sv
// RGB 5x5 convolution on line-buffer taps with double-buffered kernel
// swapped on vsync, de-edge bypass and a delay-matched status path.
module conv5x5_filter
    import conv_pkg::*;
#(
    parameter int NORM_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pa,
    input  logic [23:0] pb,
    input  logic [23:0] pc,
    input  logic [23:0] pd,
    input  logic [23:0] pe,
    input  logic [2:0]  stat_in,
    input  logic        filt_en,
    input  logic        coef_we,
    input  logic [4:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic        coef_pend,
    output logic [23:0] data_o,
    output logic [2:0]  stat_o
);
    logic [KERN_N-1:0]     r_de;
    kern_t                 r_kshd;
    kern_t                 r_kact;
    logic                  r_pend;
    logic                  r_vs_d;
    logic [LAT-1:0][2:0]   r_stat;
    logic [2:0][PIX_W-1:0] w_pix;
    logic                  w_vs_rise;
    logic                  w_wr;
    logic                  w_swap;
    logic                  w_byp;

    assign w_vs_rise = stat_in[STAT_VS] & ~r_vs_d;
    assign w_wr      = coef_we & (coef_addr < 5'(KERN_SZ));
    assign w_swap    = w_vs_rise & r_pend;
    assign w_byp     = ~filt_en | ~(&r_de);

    // shadow writes, vsync-gated swap into the active kernel
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_kshd <= ident_kern(NORM_SHIFT);
            r_kact <= ident_kern(NORM_SHIFT);
            r_pend <= 1'b0;
        end else begin
            if (w_wr) r_kshd[coef_addr] <= coef_data;
            if (w_swap) r_kact <= r_kshd;
            if (w_wr) begin
                r_pend <= 1'b1;
            end else if (w_swap) begin
                r_pend <= 1'b0;
            end
        end
    end

    // de window tracking, vsync history and status delay line
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_de   <= '0;
            r_vs_d <= 1'b0;
            r_stat <= '0;
        end else begin
            r_de   <= {stat_in[STAT_DE], r_de[KERN_N-1:1]};
            r_vs_d <= stat_in[STAT_VS];
            r_stat <= {r_stat[LAT-2:0], stat_in};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gen_ch
        conv5x5_chan #(
            .NORM_SHIFT (NORM_SHIFT)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_col  ({pe[g*PIX_W +: PIX_W], pd[g*PIX_W +: PIX_W],
                      pc[g*PIX_W +: PIX_W], pb[g*PIX_W +: PIX_W],
                      pa[g*PIX_W +: PIX_W]}),
            .i_kern (r_kact),
            .i_byp  (w_byp),
            .o_pix  (w_pix[g])
        );
    end

    assign data_o    = w_pix;
    assign stat_o    = r_stat[LAT-1];
    assign coef_pend = r_pend;
endmodule

// File: tb/tb_conv5x5_filter.sv
// Scoreboard bench for conv5x5_filter: stimulus pushes expected pixels,
// a negedge monitor pops and compares whenever stat_o shows de.
module tb_conv5x5_filter;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pa, pb, pc, pd, pe;
    logic [2:0]  stat_in;
    logic        filt_en;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        coef_pend;
    logic [23:0] data_o;
    logic [2:0]  stat_o;

    typedef struct packed {
        logic [23:0] d;
        logic [2:0]  s;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;
    int   zchk     = 0;

    localparam logic [23:0] ROWX [5] = '{24'h5A5A5A, 24'h333333, 24'h000000,
                                         24'h0F0F0F, 24'hA5A5A5};

    conv5x5_filter #(.NORM_SHIFT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pa        (pa),
        .pb        (pb),
        .pc        (pc),
        .pd        (pd),
        .pe        (pe),
        .stat_in   (stat_in),
        .filt_en   (filt_en),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_pend (coef_pend),
        .data_o    (data_o),
        .stat_o    (stat_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stat_o[0] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected data_o=%h stat_o=%b required=no output",
                         data_o, stat_o);
            end else begin
                m_e = exp_q.pop_front();
                if (data_o !== m_e.d || stat_o !== m_e.s) begin
                    failures++;
                    $display("FAIL pixel data_o=%h stat_o=%b required data=%h stat=%b",
                             data_o, stat_o, m_e.d, m_e.s);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic zcheck();
        if (zchk > 0) begin
            zchk--;
            chk("post_rst_zero", {5'b0, data_o, stat_o}, 32'h0);
        end
    endtask

    task automatic px(input logic [23:0] a, b, c, d, e,
                      input logic [2:0] st, input logic [23:0] expv);
        zcheck();
        pa = a; pb = b; pc = c; pd = d; pe = e;
        stat_in = st;
        if (st[0] && rst) exp_q.push_back(exp_t'({expv, st}));
        tick();
    endtask

    task automatic blank(input int n);
        for (int k = 0; k < n; k++) px('0, '0, '0, '0, '0, 3'b000, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        chk("rst_data", {8'b0, data_o}, 32'h0);
        chk("rst_stat", {29'b0, stat_o}, 32'h0);
        chk("rst_pend", {31'b0, coef_pend}, 32'h0);
        exp_q.delete();
        rst  = 1'b1;
        zchk = 6;
    endtask

    task automatic wcoef(input logic [4:0] a, input logic [7:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        blank(1);
        coef_we = 1'b0;
    endtask

    task automatic set_kernel(input logic [7:0] all, input int idx,
                              input logic [7:0] val);
        for (int a = 0; a < 25; a++) wcoef(5'(a), (a == idx) ? val : all);
    endtask

    task automatic vsync(input bit we, input logic [4:0] a, input logic [7:0] d);
        coef_we = we; coef_addr = a; coef_data = d;
        px('0, '0, '0, '0, '0, 3'b100, '0);
        coef_we = 1'b0;
        blank(1);
    endtask

    // kind: 0 raw, 1 const f, 2 centre pixel two columns ahead, 3 top row
    task automatic line(input int len, input logic [23:0] base, step,
                        input bit mix, input int kind, input logic [23:0] f,
                        input int rst_at = -1);
        logic [23:0] v [5];
        logic [23:0] ev;
        logic [2:0]  st;
        blank(3);
        for (int i = 0; i < len; i++) begin
            for (int r = 0; r < 5; r++)
                v[r] = (base + step * 24'(i)) ^ (mix ? ROWX[r] : 24'h0);
            ev = v[2];
            if (filt_en && i >= 2 && i < len - 2) begin
                case (kind)
                    1: ev = f;
                    2: ev = base + step * 24'(i + 2);
                    3: ev = v[0];
                    default: ev = v[2];
                endcase
            end
            st = {1'b0, i[0], 1'b1};
            if (i == rst_at) begin
                pa = v[0]; pb = v[1]; pc = v[2]; pd = v[3]; pe = v[4];
                stat_in = st;
                do_reset();
            end else begin
                px(v[0], v[1], v[2], v[3], v[4], st, ev);
            end
        end
        blank(8);
    endtask

    initial begin
        rst = 1'b0;
        pa = '0; pb = '0; pc = '0; pd = '0; pe = '0;
        stat_in = '0; filt_en = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick();
        tick();
        do_reset();

        line(20, 24'h010203, 24'h010101, 1'b1, 0, '0);

        set_kernel(8'd1, 12, 8'd1);
        chk("pend_after_write", {31'b0, coef_pend}, 32'h1);
        line(12, 24'h101010, '0, 1'b0, 0, '0);
        chk("pend_before_vs", {31'b0, coef_pend}, 32'h1);
        vsync(1'b0, '0, '0);
        chk("pend_after_vs", {31'b0, coef_pend}, 32'h0);
        line(12, 24'h101010, '0, 1'b0, 1, 24'h191919);
        wcoef(5'd25, 8'h7F);
        wcoef(5'd31, 8'h7F);
        chk("pend_bad_addr", {31'b0, coef_pend}, 32'h0);

        set_kernel(8'd0, 12, 8'hF0);
        vsync(1'b0, '0, '0);
        line(12, 24'h808080, '0, 1'b0, 1, 24'h000000);

        set_kernel(8'd8, 12, 8'd8);
        vsync(1'b0, '0, '0);
        line(12, 24'h102030, '0, 1'b0, 1, 24'hC8FFFF);
        line(10, 24'hFFFFFF, '0, 1'b0, 1, 24'hFFFFFF);

        set_kernel(8'd1, 12, 8'd1);
        chk("pend_midframe", {31'b0, coef_pend}, 32'h1);
        line(12, 24'h101010, '0, 1'b0, 1, 24'hC8C8C8);
        vsync(1'b1, 5'd12, 8'h11);
        chk("pend_vs_write", {31'b0, coef_pend}, 32'h1);
        line(12, 24'h101010, '0, 1'b0, 1, 24'h191919);
        vsync(1'b0, '0, '0);
        chk("pend_second_vs", {31'b0, coef_pend}, 32'h0);
        line(12, 24'h101010, '0, 1'b0, 1, 24'h292929);

        set_kernel(8'd0, 14, 8'd16);
        vsync(1'b0, '0, '0);
        line(14, 24'h010203, 24'h010101, 1'b1, 2, '0);
        set_kernel(8'd0, 2, 8'd16);
        vsync(1'b0, '0, '0);
        line(14, 24'h010203, 24'h010101, 1'b1, 3, '0);

        filt_en = 1'b0;
        line(14, 24'h010203, 24'h010101, 1'b1, 0, '0);
        filt_en = 1'b1;

        wcoef(5'd0, 8'd3);
        chk("pend_before_rst", {31'b0, coef_pend}, 32'h1);
        line(14, 24'h010203, 24'h010101, 1'b1, 0, '0, 5);
        chk("pend_after_rst", {31'b0, coef_pend}, 32'h0);

        blank(10);
        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
